// File: rtl/comb_gates_pairwise_if.sv
// Bus for the pairwise gate block. It carries the input vector and the three
// per-pair result vectors.
//   in_      : WIDTH-bit input vector, bit 0 is the LSB
//   out_and  : WIDTH-1 bits, in_[i+1] & in_[i]
//   out_or   : WIDTH-1 bits, in_[i+1] | in_[i]
//   out_xnor : WIDTH-1 bits, ~(in_[i+1] ^ in_[i])
// The master drives in_ and observes the results. The slave is the gate block.
interface comb_gates_pairwise_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_;
    logic [WIDTH-2:0] out_and;
    logic [WIDTH-2:0] out_or;
    logic [WIDTH-2:0] out_xnor;

    modport master (
        output in_,
        input  out_and,
        input  out_or,
        input  out_xnor
    );

    modport slave (
        input  in_,
        output out_and,
        output out_or,
        output out_xnor
    );
endinterface

// File: rtl/comb_gates_pairwise.sv
// Pairwise bitwise gate block. For each adjacent pair (in_[i+1], in_[i]) the
// block produces AND, OR and XNOR. The pairs do not wrap around.
// The block has two variants:
//   REGISTERED = 0 : the outputs are combinational, with zero latency.
//                    clk and reset are ignored.
//   REGISTERED = 1 : the outputs are registered on clk, with one cycle of
//                    latency. reset clears them asynchronously.
// Ports:
//   clk   : clock, used only when REGISTERED = 1
//   reset : asynchronous active-low reset, used only when REGISTERED = 1
//   bus   : slave side of comb_gates_pairwise_if (in_, out_and, out_or, out_xnor)
module comb_gates_pairwise #(
    parameter int WIDTH      = 4,
    parameter bit REGISTERED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    comb_gates_pairwise_if.slave  bus
);

    // Stage p0: combinational pair results.
    // The shifted slice lines up in_[i+1] against in_[i]. An X on one input bit
    // therefore reaches only the two pairs that use that bit.
    logic [WIDTH-2:0] and_p0;
    logic [WIDTH-2:0] or_p0;
    logic [WIDTH-2:0] xnor_p0;

    assign and_p0  = bus.in_[WIDTH-1:1] & bus.in_[WIDTH-2:0];
    assign or_p0   = bus.in_[WIDTH-1:1] | bus.in_[WIDTH-2:0];
    assign xnor_p0 = ~(bus.in_[WIDTH-1:1] ^ bus.in_[WIDTH-2:0]);

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-2:0] and_p1;
            logic [WIDTH-2:0] or_p1;
            logic [WIDTH-2:0] xnor_p1;

            // Stage p1: output register. It is cleared while reset is low,
            // independent of clk.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    and_p1  <= '0;
                    or_p1   <= '0;
                    xnor_p1 <= '0;
                end else begin
                    and_p1  <= and_p0;
                    or_p1   <= or_p0;
                    xnor_p1 <= xnor_p0;
                end
            end

            assign bus.out_and  = and_p1;
            assign bus.out_or   = or_p1;
            assign bus.out_xnor = xnor_p1;
        end else begin : g_comb
            // clk and reset have no function in this variant. They are folded
            // into a sink so that they do not dangle.
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;

            assign bus.out_and  = and_p0;
            assign bus.out_or   = or_p0;
            assign bus.out_xnor = xnor_p0;
        end
    endgenerate

endmodule

// File: tb/tb_comb_gates_pairwise.sv
`timescale 1ns/1ps
module tb_comb_gates_pairwise;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n_c;
    logic rst_n_r;

    comb_gates_pairwise_if #(.WIDTH(WIDTH)) bus_c ();
    comb_gates_pairwise_if #(.WIDTH(WIDTH)) bus_r ();

    comb_gates_pairwise #(.WIDTH(WIDTH), .REGISTERED(1'b0)) dut_comb (
        .clk   (clk),
        .reset (rst_n_c),
        .bus   (bus_c.slave)
    );

    comb_gates_pairwise #(.WIDTH(WIDTH), .REGISTERED(1'b1)) dut_reg (
        .clk   (clk),
        .reset (rst_n_r),
        .bus   (bus_r.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed {and, or, xnor} for in_ = 0..15 (WIDTH = 4).
    logic [8:0] exp_tab [0:15] = '{
        9'b000_000_111,  // 0000
        9'b000_001_110,  // 0001
        9'b000_011_100,  // 0010
        9'b001_011_101,  // 0011
        9'b000_110_001,  // 0100
        9'b000_111_000,  // 0101
        9'b010_111_010,  // 0110
        9'b011_111_011,  // 0111
        9'b000_100_011,  // 1000
        9'b000_101_010,  // 1001
        9'b000_111_000,  // 1010
        9'b001_111_001,  // 1011
        9'b100_110_101,  // 1100
        9'b100_111_100,  // 1101
        9'b110_111_110,  // 1110
        9'b111_111_111   // 1111
    };

    typedef struct {
        realtime    due;
        logic [2:0] a;
        logic [2:0] o;
        logic [2:0] x;
        string      name;
    } exp_t;

    exp_t q_c[$];
    exp_t q_r[$];

    int checks = 0;
    int errors = 0;

    task automatic push_c(input string name, input logic [8:0] e, input realtime dly);
        exp_t t;
        t.due = $realtime + dly; t.a = e[8:6]; t.o = e[5:3]; t.x = e[2:0]; t.name = name;
        q_c.push_back(t);
    endtask

    task automatic push_r(input string name, input logic [8:0] e, input realtime dly);
        exp_t t;
        t.due = $realtime + dly; t.a = e[8:6]; t.o = e[5:3]; t.x = e[2:0]; t.name = name;
        q_r.push_back(t);
    endtask

    // Monitor. It samples on half-ns offsets, which keeps it clear of clock
    // edges and stimulus updates. It pops every entry that has come due.
    initial begin
        exp_t e;
        #0.5;
        forever begin
            while (q_c.size() > 0 && q_c[0].due <= $realtime) begin
                e = q_c.pop_front();
                checks++;
                if (bus_c.out_and !== e.a || bus_c.out_or !== e.o || bus_c.out_xnor !== e.x) begin
                    errors++;
                    $display("FAIL comb %s @%0t: got and=%b or=%b xnor=%b, expected and=%b or=%b xnor=%b",
                             e.name, $realtime, bus_c.out_and, bus_c.out_or, bus_c.out_xnor, e.a, e.o, e.x);
                end
            end
            while (q_r.size() > 0 && q_r[0].due <= $realtime) begin
                e = q_r.pop_front();
                checks++;
                if (bus_r.out_and !== e.a || bus_r.out_or !== e.o || bus_r.out_xnor !== e.x) begin
                    errors++;
                    $display("FAIL reg %s @%0t: got and=%b or=%b xnor=%b, expected and=%b or=%b xnor=%b",
                             e.name, $realtime, bus_r.out_and, bus_r.out_or, bus_r.out_xnor, e.a, e.o, e.x);
                end
            end
            #1;
        end
    end

    // Combinational variant: exhaustive sweep. Each value is held for one
    // cycle and checked before the next edge. Reset is pulsed low partway
    // through and must have no effect.
    task automatic stim_comb();
        for (int v = 0; v < 16; v++) begin
            @(posedge clk);
            #1;
            bus_c.in_ = v[3:0];
            if (v == 5) rst_n_c = 1'b0;
            if (v == 8) rst_n_c = 1'b1;
            push_c($sformatf("sweep_%0d", v), exp_tab[v], 3.0);
        end
    endtask

    // Registered variant: capture, async clear, release, stream, mid-stream clear.
    task automatic stim_reg();
        @(posedge clk);
        #1;
        push_r("capture_1111", exp_tab[15], 1.0);
        #2;
        rst_n_r = 1'b0;                      // between edges
        push_r("async_clear", 9'b0, 1.0);
        bus_r.in_ = 4'b0101;
        @(posedge clk);
        #2;
        push_r("held_in_reset", 9'b0, 1.0);
        #1;
        bus_r.in_ = 4'b0011;
        rst_n_r   = 1'b1;                    // released between edges
        push_r("no_capture_before_edge", 9'b0, 1.0);
        @(posedge clk);
        #1;
        push_r("first_capture_0011", exp_tab[3], 1.0);
        bus_r.in_ = 4'b0101;
        push_r("hold_0011_before_edge", exp_tab[3], 2.0);
        @(posedge clk);
        #1;
        push_r("stream_0101", exp_tab[5], 1.0);
        bus_r.in_ = 4'b1000;
        @(posedge clk);
        #1;
        push_r("stream_1000", exp_tab[8], 1.0);
        bus_r.in_ = 4'b1111;
        #2;
        rst_n_r = 1'b0;                      // mid-stream, between edges
        push_r("midstream_clear", 9'b0, 1.0);
        @(posedge clk);
        #2;
        push_r("midstream_held", 9'b0, 1.0);
        #1;
        rst_n_r = 1'b1;
        @(posedge clk);
        #1;
        push_r("recover_1111", exp_tab[15], 1.0);
    endtask

    initial begin
        rst_n_c   = 1'b1;
        rst_n_r   = 1'b1;
        bus_c.in_ = '0;
        bus_r.in_ = 4'b1111;
        fork
            stim_comb();
            stim_reg();
        join
        for (int i = 0; i < 50 && (q_c.size() + q_r.size()) > 0; i++) @(negedge clk);
        if ((q_c.size() + q_r.size()) > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", q_c.size() + q_r.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time=%0t limit=20000", $realtime);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/comb_gates_pairwise.md
Name: comb_gates_pairwise

Overview:
Pairwise bitwise gate block: for each pair of adjacent input bits, it produces the AND, OR and XNOR results. By default the datapath is purely combinational, with zero latency. An optional output register stage, selected by parameter, lets the block sit on a pipelined boundary. The block is a small leaf used wherever adjacent-bit relations (equality, both set, either set) are needed.

Parameters:
WIDTH, 4, number of input bits (>= 2); each output is WIDTH-1 bits.
REGISTERED, 0, 0 = outputs combinational from in_; 1 = outputs registered on clk.

Ports:
clk  input  1  clock; used only when REGISTERED=1.
reset  input  1  asynchronous, active-low reset; used only when REGISTERED=1.
in_  input  WIDTH  input vector; bit 0 is the LSB.
out_and  output  WIDTH-1  out_and[i] = in_[i+1] AND in_[i].
out_or  output  WIDTH-1  out_or[i] = in_[i+1] OR in_[i].
out_xnor  output  WIDTH-1  out_xnor[i] = NOT(in_[i+1] XOR in_[i]).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Bit index i runs from 0 to WIDTH-2. Pair i is (in_[i+1], in_[i]). No wrap-around: there is no pair (in_[0], in_[WIDTH-1]).
- out_xnor[i] is 1 exactly when the two adjacent bits are equal.
- REGISTERED=0:
  - All outputs are pure combinational functions of in_, with zero-cycle latency.
  - clk and reset are ignored; reset does not force the outputs.
  - No latches and no internal state.
  - Outputs must settle within the same cycle that in_ changes.
- REGISTERED=1:
  - Each output is captured on the rising edge of clk from the combinational result of in_, giving 1-cycle latency.
  - While reset is low, out_and, out_or and out_xnor are all forced to 0 immediately, without waiting for a clock edge.
  - The first capture happens on the first rising edge after reset deasserts.
  - Reset asserted mid-operation clears the outputs asynchronously.
- Any X or Z on in_ bits may propagate only to the outputs of the pairs that use that bit.
- No arithmetic is performed; widths are exact and nothing is truncated or extended.

Test Plan:
- REGISTERED=0, in_=4'b0000 -> out_and=3'b000, out_or=3'b000, out_xnor=3'b111.
- REGISTERED=0, in_=4'b0011 -> out_and=3'b001, out_or=3'b011, out_xnor=3'b101.
- REGISTERED=0, in_=4'b0101 -> out_and=3'b000, out_or=3'b111, out_xnor=3'b000.
- REGISTERED=0, in_=4'b1000 -> out_and=3'b000, out_or=3'b100, out_xnor=3'b011; in_=4'b1111 -> out_and=3'b111, out_or=3'b111, out_xnor=3'b111.
- REGISTERED=0, exhaustive sweep of in_ from 0 to 15, with each value held for one cycle and the outputs checked before the next edge -> every bit matches the per-pair formulas above.
- REGISTERED=1 check, in three steps:
  - Assert reset low between clock edges -> outputs go to 0 immediately.
  - Release reset with in_=4'b0011 -> outputs become 001/011/101 one cycle later.
  - Re-assert reset mid-stream -> outputs clear asynchronously.
